// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared encodings for the memory port arbiter
package mem_arbiter_pkg;

  localparam int MEM_LATENCY_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_I = 2'd1,
    ST_GRANT_D = 2'd2,
    ST_DRAIN   = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - arbiter to main memory bus
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  logic              mem_enable;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;
  logic              mem_data_valid;

  modport master (
    output mem_enable, mem_wr, mem_addr, mem_data_in,
    input  mem_data_out, mem_data_valid
  );

  modport slave (
    input  mem_enable, mem_wr, mem_addr, mem_data_in,
    output mem_data_out, mem_data_valid
  );

endinterface

// File: rtl/mem_owner_pipe.sv
// rtl/mem_owner_pipe.sv - owner tag shift register aligned with memory read latency
module mem_owner_pipe
  import mem_arbiter_pkg::*;
#(
  parameter int DEPTH = MEM_LATENCY_DEF,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_i,
  input  owner_e           owner_i,
  output logic             tail_valid_o,
  output owner_e           tail_owner_o,
  output logic [CNT_W-1:0] inflight_o
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] owner_q, owner_d;

  assign valid_d = {valid_q[DEPTH-2:0], issue_i};
  assign owner_d = {owner_q[DEPTH-2:0], owner_i};

  always_ff @(posedge clk) begin
    if (rst_n) begin
      valid_q <= '0;
      owner_q <= '0;
    end else begin
      valid_q <= valid_d;
      owner_q <= owner_d;
    end
  end

  // Tail stage holds the read whose data arrives this cycle.
  assign tail_valid_o = valid_q[DEPTH-1];
  assign tail_owner_o = owner_e'(owner_q[DEPTH-1]);

  always_comb begin
    inflight_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      inflight_o = inflight_o + CNT_W'(valid_q[k]);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port arbiter for I fill, D fill and D write-through stores
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY = MEM_LATENCY_DEF,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic              i_mem_enable,
  input  logic [ADDR_W-1:0] i_mem_address,
  output logic              i_grant,
  output logic [DATA_W-1:0] i_memory_data,
  output logic              i_memory_data_valid,
  input  logic              d_req,
  input  logic              d_mem_enable,
  input  logic [ADDR_W-1:0] d_mem_address,
  output logic              d_grant,
  output logic [DATA_W-1:0] d_memory_data,
  output logic              d_memory_data_valid,
  input  logic              d_wr_en,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  output logic              d_wr_ack,
  mem_arbiter_if.master     mem_bus,
  output logic              proto_err
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  arb_state_e       state_q, state_d;
  logic             proto_err_q, proto_err_d;
  logic [CNT_W-1:0] blank_q, blank_d;
  logic             issue;
  owner_e           issue_owner;
  logic             tail_valid;
  owner_e           tail_owner;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] remaining;

  mem_owner_pipe #(
    .DEPTH (MEM_LATENCY),
    .CNT_W (CNT_W)
  ) u_owner_pipe (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_i      (issue),
    .owner_i      (issue_owner),
    .tail_valid_o (tail_valid),
    .tail_owner_o (tail_owner),
    .inflight_o   (inflight)
  );

  // Reads still outstanding once this cycle's returning word has been taken.
  assign remaining = inflight - CNT_W'(tail_valid);

  always_comb begin
    state_d             = state_q;
    i_grant             = 1'b0;
    d_grant             = 1'b0;
    d_wr_ack            = 1'b0;
    mem_bus.mem_enable  = 1'b0;
    mem_bus.mem_wr      = 1'b0;
    mem_bus.mem_addr    = '0;
    mem_bus.mem_data_in = '0;
    issue               = 1'b0;
    issue_owner         = OWN_I;
    unique case (state_q)
      ST_IDLE: begin
        if (d_wr_en) begin
          d_wr_ack            = 1'b1;
          mem_bus.mem_enable  = 1'b1;
          mem_bus.mem_wr      = 1'b1;
          mem_bus.mem_addr    = d_wr_addr;
          mem_bus.mem_data_in = d_wr_data;
        end else if (d_req) begin
          d_grant            = 1'b1;
          mem_bus.mem_enable = d_mem_enable;
          mem_bus.mem_addr   = d_mem_address;
          issue              = d_mem_enable;
          issue_owner        = OWN_D;
          state_d            = ST_GRANT_D;
        end else if (i_req) begin
          i_grant            = 1'b1;
          mem_bus.mem_enable = i_mem_enable;
          mem_bus.mem_addr   = i_mem_address;
          issue              = i_mem_enable;
          issue_owner        = OWN_I;
          state_d            = ST_GRANT_I;
        end
      end
      ST_GRANT_I: begin
        i_grant            = 1'b1;
        mem_bus.mem_enable = i_mem_enable;
        mem_bus.mem_addr   = i_mem_address;
        issue              = i_mem_enable;
        issue_owner        = OWN_I;
        if (!i_req) begin
          state_d = (issue || remaining != '0) ? ST_DRAIN : ST_IDLE;
        end
      end
      ST_GRANT_D: begin
        d_grant            = 1'b1;
        mem_bus.mem_enable = d_mem_enable;
        mem_bus.mem_addr   = d_mem_address;
        issue              = d_mem_enable;
        issue_owner        = OWN_D;
        if (!d_req) begin
          state_d = (issue || remaining != '0) ? ST_DRAIN : ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (remaining == '0) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign i_memory_data       = mem_bus.mem_data_out;
  assign d_memory_data       = mem_bus.mem_data_out;
  assign i_memory_data_valid = mem_bus.mem_data_valid & tail_valid & (tail_owner == OWN_I);
  assign d_memory_data_valid = mem_bus.mem_data_valid & tail_valid & (tail_owner == OWN_D);

  // After reset, untracked returns from abandoned reads are silently dropped.
  always_comb begin
    blank_d     = (blank_q != '0) ? blank_q - CNT_W'(1) : blank_q;
    proto_err_d = proto_err_q |
                  (mem_bus.mem_data_valid & ~tail_valid & (blank_q == '0));
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= ST_IDLE;
      proto_err_q <= 1'b0;
      blank_q     <= CNT_W'(MEM_LATENCY);
    end else begin
      state_q     <= state_d;
      proto_err_q <= proto_err_d;
      blank_q     <= blank_d;
    end
  end

  assign proto_err = proto_err_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-port arbiter between the I-cache fill FSM, the D-cache fill FSM and D-cache write-through stores, in front of the shared 4-cycle-latency main memory.
- Grants the memory port to one requester per fill and tracks every in-flight read with an owner tag.
- Steers each returning word and its valid flag only to the requester that issued the read.
- Sits downstream of both fill FSMs and upstream of the memory model.

Parameters:
- MEM_LATENCY, 4: cycles from a read issue (mem_enable=1, mem_wr=0) to mem_data_valid.
- ADDR_W, 16: address width.
- DATA_W, 16: data width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous and active-high (name kept as in the codebase)
- i_req  in  1  I fill FSM busy
- i_mem_enable  in  1  I fill read strobe
- i_mem_address  in  16  I fill read address
- i_grant  out  1  port owned by I side; integration gates I miss_detected with this
- i_memory_data  out  16  returned word
- i_memory_data_valid  out  1  returned word valid, I side only
- d_req, d_mem_enable, d_mem_address, d_grant, d_memory_data, d_memory_data_valid  same widths and meanings, D side
- d_wr_en  in  1  write-through store request
- d_wr_addr  in  16  store address
- d_wr_data  in  16  store data
- d_wr_ack  out  1  store accepted this cycle
- mem_enable  out  1  to memory
- mem_wr  out  1  to memory
- mem_addr  out  16  to memory
- mem_data_in  out  16  to memory
- mem_data_out  in  16  from memory
- mem_data_valid  in  1  from memory
- proto_err  out  1  sticky; valid returned with no tracked read

Behaviour:
- States: IDLE, GRANT_I, GRANT_D, DRAIN. Reset → IDLE.
- Reset values: all outputs 0, owner pipeline cleared, proto_err=0. A reset mid-fill abandons in-flight reads; their late returns are discarded and do not set proto_err.
- IDLE priority: d_wr_en > d_req > i_req.
  - d_wr_en: d_wr_ack=1, single-cycle write (mem_enable=1, mem_wr=1, mem_addr=d_wr_addr, mem_data_in=d_wr_data). Stay IDLE. Both grants 0 that cycle.
  - Else d_req: d_grant=1 combinationally in the same cycle, so the requester's first read issues in the request cycle. Go to GRANT_D.
  - Else i_req: i_grant=1 combinationally, same handshake. Go to GRANT_I.
- GRANT_x:
  - grant_x=1; mem_enable=x_mem_enable, mem_addr=x_mem_address, mem_wr=0.
  - The other requester's enable is ignored. d_wr_en is never acked outside IDLE.
  - Exit when x_req=0: go to IDLE if no reads are in flight, else DRAIN.
  - A same-cycle new request is not granted until IDLE.
- DRAIN: no grants, mem_enable=0. Go to IDLE when the in-flight count reaches 0.
- Owner tracking:
  - MEM_LATENCY-deep shift register of {valid, owner}. Entry 0 is loaded on each read issue; the tail is aligned with mem_data_valid.
  - mem_data_valid with tail.valid=1 → route to tail.owner: x_memory_data=mem_data_out, x_memory_data_valid=1. The other side's valid=0.
  - mem_data_valid with tail.valid=0 → drop the word; proto_err←1 until reset.
  - Data outputs are combinational from mem_data_out; valids are the only qualifier.
- In-flight count: 0..MEM_LATENCY, derived from the valid bits or a 3-bit counter; must not wrap.
- Back-to-back issues every cycle are supported: a full fill is 8 issues, MEM_LATENCY+8 cycles total.
- Writes do not enter the owner pipeline.

Decomposition:
- Shared package holds the state encoding (IDLE/GRANT_I/GRANT_D/DRAIN), owner encoding (OWN_I=0, OWN_D=1) and MEM_LATENCY default.
- One natural sub-module: mem_owner_pipe, the tag shift register with in-flight count and tail outputs, built from the codebase dff cells.

Test Plan:
- Lone I fill: i_req plus 8 reads at addresses 0x1230..0x123E → i_grant the same cycle, memory sees 8 reads, i_memory_data_valid on cycles 4..11, d_memory_data_valid stays 0, IDLE at cycle 12.
- Simultaneous i_req and d_req in IDLE → D granted first and completes its 8 words. i_grant asserts on the first IDLE cycle afterwards, and I data returns only to I.
- d_wr_en with d_req in IDLE → d_wr_ack=1, mem_wr=1, addr/data passed through. d_grant follows the next cycle.
- Requester drops busy with 2 reads in flight → DRAIN. Both words still routed to the original owner, then IDLE. A new i_req is held off during DRAIN.
- Spurious mem_data_valid in IDLE → no valid output asserted, proto_err=1 and held until reset.
- Reset asserted mid-fill after 3 issues → outputs 0 next cycle, late returns dropped, proto_err stays 0.
